// File: rtl/io_responder_pkg.sv
// Shared constants for the memory-mapped I/O responder.
// Covers the I/O region decode value, the register offsets and the bus data width.
package io_responder_pkg;

  localparam logic [1:0] IO_REGION   = 2'b11;
  localparam logic [2:0] IO_OFF_UART = 3'd0;
  localparam logic [2:0] IO_OFF_CLK  = 3'd4;
  localparam int         MEM_DAT_W   = 8;

  // Register offsets inside the I/O window (1..3 are reserved)
  typedef enum logic [2:0] {
    OFF_UART = 3'd0,
    OFF_RSV1 = 3'd1,
    OFF_RSV2 = 3'd2,
    OFF_RSV3 = 3'd3,
    OFF_CLK0 = 3'd4,
    OFF_CLK1 = 3'd5,
    OFF_CLK2 = 3'd6,
    OFF_CLK3 = 3'd7
  } io_off_e;

  // True when the region bits of a CPU address select the I/O window
  function automatic logic is_io_region(input logic [1:0] region_bits);
    return region_bits == IO_REGION;
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU byte-bus connection between the CPU (master) and the I/O responder (slave).
interface io_responder_if;
  import io_responder_pkg::*;

  logic [31:0]          mem_a;
  logic                 mem_wr;
  logic [MEM_DAT_W-1:0] mem_dout;
  logic [MEM_DAT_W-1:0] cpu_din;
  logic                 rd_io_q;
  logic                 io_buffer_full;

  modport master (
    output mem_a, mem_wr, mem_dout,
    input  cpu_din, rd_io_q, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout,
    output cpu_din, rd_io_q, io_buffer_full
  );

endinterface

// File: rtl/io_responder_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
  import io_responder_pkg::*;
#(
  parameter int W  = MEM_DAT_W,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [AW:0]  count_next
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array needs no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and count state, cleared asynchronously so a reset drops all contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: UART TX/RX byte ports, 32-bit cycle counter with
// coherent snapshot, and the program-stop register.
// Optional RX FIFO is built only when the IO_RX_FIFO_EN macro is defined.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int TX_AW       = 4,
  parameter int RX_AW       = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  io_responder_if.slave        bus,
  output logic [MEM_DAT_W-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [MEM_DAT_W-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 program_done
);

  localparam int TX_DEPTH = 1 << TX_AW;
  localparam logic [TX_AW:0] FULL_THR = (TX_AW+1)'(TX_DEPTH - FULL_MARGIN);

  logic                 hit;
  logic                 rd_hit;
  logic                 wr_hit;
  io_off_e              off;
  logic                 tx_push;
  logic [MEM_DAT_W-1:0] tx_din;
  logic                 tx_pop;
  logic                 tx_empty;
  logic [TX_AW:0]       tx_count_next;
  logic                 rx_empty;
  logic [MEM_DAT_W-1:0] rx_head;
  logic [MEM_DAT_W-1:0] rd_byte;
  logic [31:0]          counter;
  logic [31:0]          snapshot;
  logic                 stop_req;
  logic                 done_q;
  logic [MEM_DAT_W-1:0] cpu_din_q;
  logic                 rd_io_q_q;
  logic                 buf_full_q;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{bus.mem_a[31:18], bus.mem_a[15:3]};

  assign hit    = en & is_io_region(bus.mem_a[17:16]);
  assign off    = io_off_e'(bus.mem_a[2:0]);
  assign rd_hit = hit & ~bus.mem_wr;
  assign wr_hit = hit & bus.mem_wr;

  // A zero byte written to the UART port is swallowed; a stop write queues a 0x00 marker
  assign tx_push = wr_hit & (((off == IO_OFF_UART) & (bus.mem_dout != '0)) | (off == IO_OFF_CLK));
  assign tx_din  = (off == IO_OFF_CLK) ? '0 : bus.mem_dout;
  assign tx_pop  = tx_valid & tx_ready;

  sync_fifo #(.W(MEM_DAT_W), .AW(TX_AW)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (tx_push),
    .din        (tx_din),
    .pop        (tx_pop),
    .dout       (tx_data),
    .empty      (tx_empty),
    .count_next (tx_count_next)
  );

  assign tx_valid = ~tx_empty;

`ifdef IO_RX_FIFO_EN
  localparam int RX_DEPTH = 1 << RX_AW;

  logic             rx_pop;
  logic [RX_AW:0]   rx_count_next;
  logic             rx_ready_q;

  assign rx_pop = rd_hit & (off == IO_OFF_UART) & ~rx_empty;

  sync_fifo #(.W(MEM_DAT_W), .AW(RX_AW)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rx_valid & rx_ready),
    .din        (rx_data),
    .pop        (rx_pop),
    .dout       (rx_head),
    .empty      (rx_empty),
    .count_next (rx_count_next)
  );

  // Advertise room for another UART byte based on next cycle's occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_ready_q <= 1'b1;
    else     rx_ready_q <= (rx_count_next != (RX_AW+1)'(RX_DEPTH));
  end

  assign rx_ready = rx_ready_q;
`else
  logic unused_rx;

  assign unused_rx = ^{rx_data, rx_valid};
  assign rx_empty  = 1'b1;
  assign rx_head   = '0;
  assign rx_ready  = 1'b0;
`endif

  // Read data mux: RX head, live counter low byte, or snapshot upper bytes
  always_comb begin
    rd_byte = '0;
    case (off)
      OFF_UART: rd_byte = rx_empty ? '0 : rx_head;
      OFF_CLK0: rd_byte = counter[7:0];
      OFF_CLK1: rd_byte = snapshot[15:8];
      OFF_CLK2: rd_byte = snapshot[23:16];
      OFF_CLK3: rd_byte = snapshot[31:24];
      default:  rd_byte = '0;
    endcase
  end

  // One-cycle read response; cpu_din holds between I/O reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_din_q <= '0;
      rd_io_q_q <= 1'b0;
    end else begin
      rd_io_q_q <= rd_hit;
      if (rd_hit) cpu_din_q <= rd_byte;
    end
  end

  // Free-running cycle counter; reading the low byte freezes the full value for the upper bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter  <= '0;
      snapshot <= '0;
    end else begin
      if (en) counter <= counter + 1'b1;
      if (rd_hit && off == OFF_CLK0) snapshot <= counter;
    end
  end

  // Sticky stop request and completion flag once the TX queue has drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_req <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (wr_hit && off == OFF_CLK0) stop_req <= 1'b1;
      if (stop_req && tx_empty) done_q <= 1'b1;
    end
  end

  // Back-pressure to the CPU, leaving headroom for writes already in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_full_q <= 1'b0;
    else     buf_full_q <= (tx_count_next >= FULL_THR);
  end

  assign program_done       = done_q | (stop_req & tx_empty);
  assign bus.cpu_din        = cpu_din_q;
  assign bus.rd_io_q        = rd_io_q_q;
  assign bus.io_buffer_full = buf_full_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder.
// TX bytes are scoreboarded: expected bytes queue up as writes are issued and are
// compared as the UART side consumes them.
module tb_io_responder;
  import io_responder_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       program_done;

  io_responder_if bus ();

  io_responder dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .bus          (bus),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .program_done (program_done)
  );

  int         checks;
  int         errors;
  int         tx_seen;
  int         cyc;
  logic [7:0] sbq[$];
  logic       pend_push;
  logic [7:0] pend_byte;
  logic [7:0] popped;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: watch the UART TX side at negedge, then step past the rising edge
  task automatic tick();
    @(negedge clk);
    if (!rst && tx_valid && tx_ready) begin
      tx_seen++;
      checks++;
      assert (sbq.size() != 0)
      else begin
        errors++;
        $error("[TB] FAIL tx_unexpected: observed byte 0x%0h expected no byte", tx_data);
      end
      if (sbq.size() != 0) begin
        popped = sbq.pop_front();
        checkOutput("tx_byte", 32'(tx_data), 32'(popped));
      end
    end
    if (pend_push) begin
      if (sbq.size() < 16) sbq.push_back(pend_byte);
      pend_push = 1'b0;
    end
    @(posedge clk);
    if (en && !rst) cyc++;
    #1;
  endtask

  // Drive one bus cycle, predict any TX push, then return the bus to idle
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [7:0] data);
    bus.mem_a    = addr;
    bus.mem_wr   = wr;
    bus.mem_dout = data;
    if (en && addr[17:16] == 2'b11 && wr) begin
      if (addr[2:0] == 3'd0 && data != 8'h00) begin
        pend_push = 1'b1;
        pend_byte = data;
      end else if (addr[2:0] == 3'd4) begin
        pend_push = 1'b1;
        pend_byte = 8'h00;
      end
    end
    tick();
    bus.mem_a    = 32'h0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [7:0] exp);
    applyStimulus(addr, 1'b0, 8'h00);
    checkOutput({tag, "_rdq"}, 32'(bus.rd_io_q), 32'd1);
    checkOutput(tag, 32'(bus.cpu_din), 32'(exp));
  endtask

  initial begin
    logic [31:0] exp_cnt;
    int          seen0;
    int          n;

    checks = 0; errors = 0; tx_seen = 0; cyc = 0;
    pend_push = 1'b0; pend_byte = 8'h00;
    rst = 1'b1; en = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    bus.mem_a = 32'h0; bus.mem_wr = 1'b0; bus.mem_dout = 8'h00;

    #3;
    checkOutput("rst_cpu_din", 32'(bus.cpu_din), 32'h0);
    checkOutput("rst_rd_io_q", 32'(bus.rd_io_q), 32'h0);
    checkOutput("rst_buf_full", 32'(bus.io_buffer_full), 32'h0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("rst_done", 32'(program_done), 32'h0);
`ifdef IO_RX_FIFO_EN
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'h1);
`else
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; cyc = 0;

    $display("[TB] single byte plus ignored zero byte");
    tx_ready = 1'b1;
    seen0 = tx_seen;
    applyStimulus(32'h0003_0000, 1'b1, 8'h41);
    applyStimulus(32'h0003_0000, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("tx_one_count", 32'(tx_seen - seen0), 32'd1);
    checkOutput("tx_one_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] fill TX FIFO with UART stalled");
    tx_ready = 1'b0;
    for (int i = 1; i <= 13; i++) applyStimulus(32'h0003_0000, 1'b1, 8'(8'h20 + i));
    checkOutput("buf_full_at13", 32'(bus.io_buffer_full), 32'd0);
    applyStimulus(32'h0003_0000, 1'b1, 8'h2E);
    checkOutput("buf_full_at14", 32'(bus.io_buffer_full), 32'd1);
    for (int i = 15; i <= 17; i++) applyStimulus(32'h0003_0000, 1'b1, 8'(8'h20 + i));
    checkOutput("fill_model_depth", 32'(sbq.size()), 32'd16);
    checkOutput("fill_tx_valid", 32'(tx_valid), 32'd1);
    seen0 = tx_seen;
    tx_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin tick(); n++; end
    tick(); tick();
    checkOutput("fill_drained", 32'(sbq.size()), 32'd0);
    checkOutput("fill_emitted", 32'(tx_seen - seen0), 32'd16);
    checkOutput("buf_full_cleared", 32'(bus.io_buffer_full), 32'd0);
    checkOutput("tx_valid_idle", 32'(tx_valid), 32'd0);

    $display("[TB] counter dword read");
    for (int i = 0; i < 100; i++) tick();
    exp_cnt = 32'(cyc);
    readCheck("cnt_b0", 32'h0003_0004, exp_cnt[7:0]);
    readCheck("cnt_b1", 32'h0003_0005, exp_cnt[15:8]);
    readCheck("cnt_b2", 32'h0003_0006, exp_cnt[23:16]);
    readCheck("cnt_b3", 32'h0003_0007, exp_cnt[31:24]);
    readCheck("rsv_read", 32'h0003_0001, 8'h00);
    applyStimulus(32'h0000_0004, 1'b0, 8'h00);
    checkOutput("ram_read_rdq", 32'(bus.rd_io_q), 32'd0);

    $display("[TB] bus frozen while en is low");
    readCheck("pre_freeze", 32'h0003_0007, exp_cnt[31:24]);
    en = 1'b0;
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    checkOutput("freeze_rdq", 32'(bus.rd_io_q), 32'd0);
    checkOutput("freeze_din", 32'(bus.cpu_din), 32'(exp_cnt[31:24]));
    en = 1'b1;

    $display("[TB] RX byte port");
    rx_data = 8'h5A; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
`ifdef IO_RX_FIFO_EN
    checkOutput("rx_ready_on", 32'(rx_ready), 32'd1);
    readCheck("rx_first", 32'h0003_0000, 8'h5A);
`else
    checkOutput("rx_ready_off", 32'(rx_ready), 32'd0);
    readCheck("rx_first", 32'h0003_0000, 8'h00);
`endif
    readCheck("rx_second", 32'h0003_0000, 8'h00);

    $display("[TB] stop request drains TX");
    tx_ready = 1'b1;
    applyStimulus(32'h0003_0000, 1'b1, 8'h61);
    applyStimulus(32'h0003_0000, 1'b1, 8'h62);
    applyStimulus(32'h0003_0000, 1'b1, 8'h63);
    applyStimulus(32'h0003_0004, 1'b1, 8'hFF);
    checkOutput("stop_not_done", 32'(program_done), 32'd0);
    n = 0;
    while (!program_done && n < 10) begin tick(); n++; end
    checkOutput("stop_done", 32'(program_done), 32'd1);
    checkOutput("stop_drained", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("stop_sticky", 32'(program_done), 32'd1);

    $display("[TB] asynchronous reset mid-drain");
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(32'h0003_0000, 1'b1, 8'(8'h70 + i));
    tx_ready = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    sbq.delete();
    pend_push = 1'b0;
    cyc = 0;
    checkOutput("arst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("arst_done", 32'(program_done), 32'd0);
    checkOutput("arst_counter", dut.counter, 32'd0);
    checkOutput("arst_rdq", 32'(bus.rd_io_q), 32'd0);
    tick(); tick();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    readCheck("post_rst_snapshot", 32'h0003_0005, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
